mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates the single byte-serial memory engine between instruction fetch (IC) and the load/store buffer (LSB).
//  - Registers the winning request and issues it as one start pulse to the engine.
//  - Routes the completion back to the right requester.
//  - Guarantees IC forward progress under LSB pressure and holds IO stores while io_buffer_full.
//  - Sits between icache/lsb and the byte-serial memory engine.
// PARAMETERS
//  STARVE_LIMIT  4      consecutive LSB grants with IC pending before IC is forced to win
//  CNT_W         3      width of starvation counter (must hold STARVE_LIMIT)
//  IO_SEL        2'b11  addr[17:16] value identifying memory-mapped IO
// PORTS
//  clk           in   1   clock, posedge
//  rst           in   1   synchronous reset, active-low
//  rdy           in   1   global enable; low = freeze all state
//  clear         in   1   fetch flush (mispredict); kills pending/in-flight IC work
//  io_buffer_full in  1   UART buffer full
//  ic_req        in   1   IC fetch request, held until ic_gnt
//  ic_addr       in   32  fetch address
//  ic_gnt        out  1   1-cycle pulse: IC request accepted
//  ic_done       out  1   1-cycle pulse: ic_data valid
//  ic_data       out  32  fetched word
//  lsb_req       in   1   LSB request, held until lsb_gnt
//  lsb_we        in   1   1 = store, 0 = load
//  lsb_sign      in   1   sign-extend load (LB/LH)
//  lsb_size      in   2   0 = byte, 1 = half, 3 = word
//  lsb_addr      in   32  data address
//  lsb_wdata     in   32  store data
//  lsb_gnt       out  1   1-cycle pulse: LSB request accepted
//  lsb_done      out  1   1-cycle pulse: access complete; lsb_rdata valid for loads
//  lsb_rdata     out  32  load result
//  mc_start      out  1   1-cycle pulse: start engine with mc_* fields
//  mc_we,mc_sign out  1   forwarded access type
//  mc_size       out  2   forwarded size (IC always 3)
//  mc_addr       out  32  forwarded address
//  mc_wdata      out  32  forwarded store data
//  mc_done       in   1   engine completion pulse
//  mc_rdata      in   32  engine read data, valid with mc_done
// BEHAVIOUR
//  Reset (rst == 0 at posedge):
//   - Every output 0; state IDLE; starve_cnt 0; ic_kill 0.
//  rdy low:
//   - All registers hold. No pulse is generated or extended.
//  FSM: IDLE, BUSY_IC, BUSY_LSB. Exactly one access outstanding at the engine.
//  Eligibility in IDLE:
//   - lsb_ok = lsb_req && !(lsb_we && lsb_addr[17:16] == IO_SEL && io_buffer_full).
//   - ic_ok  = ic_req && !clear.
//  Winner in IDLE:
//   - ic_ok && (!lsb_ok || starve_cnt == STARVE_LIMIT) -> IC. Otherwise lsb_ok -> LSB. Else stay IDLE.
//  Grant cycle (registered, one cycle after the IDLE decision):
//   - Assert mc_start, the winner's gnt, and the mc_* fields.
//   - Move to BUSY_IC or BUSY_LSB.
//   - IC grant: mc_we = 0, mc_size = 3.
//  starve_cnt:
//   - +1 (saturating at STARVE_LIMIT) on an LSB grant while ic_req is high.
//   - Cleared on an IC grant, or when ic_req is low.
//  Completion:
//   - On mc_done in BUSY_x: next cycle, pulse x_done and drive x_data/x_rdata from mc_rdata (registered). Return to IDLE.
//   - The arbiter is eligible to grant again in the same cycle as the done pulse.
//   - mc_done seen in IDLE is ignored.
//  clear:
//   - In BUSY_IC it sets ic_kill. When that access completes, ic_done stays 0 and ic_data is unchanged. ic_kill then clears.
//   - clear has no effect on LSB traffic.
//  IO store blocked by io_buffer_full: stays ungranted (IC may be granted meanwhile). Granted in the first IDLE cycle after io_buffer_full drops.
//  Minimum request-to-start latency: 1 cycle. Done latency: mc_done + 1 cycle.
// TESTING
//  - IC-only: ic_req, ic_addr=0x1000. Required: ic_gnt and mc_start 1 cycle later, mc_addr=0x1000, mc_size=3. mc_done with mc_rdata=0xDEADBEEF -> ic_done next cycle, ic_data=0xDEADBEEF.
//  - Simultaneous ic_req + lsb_req (load, 0x2000), starve_cnt=0. Required: LSB granted first; IC granted in the IDLE cycle after lsb_done.
//  - Starvation: lsb_req held high for 6 back-to-back loads, ic_req high throughout. Required: grants L,L,L,L,I,L,...; starve_cnt reads 4 before the IC grant.
//  - IO store: lsb_addr=0x30000, lsb_we=1, io_buffer_full=1 for 5 cycles, ic_req idle. Required: no mc_start; grant 1 cycle after io_buffer_full falls.
//  - clear during BUSY_IC. Required: mc_done arrives but no ic_done; next ic_req granted normally. Also: rst=0 mid-BUSY_LSB -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters (icache, load/store buffer), the
// arbiter and the byte-serial memory engine.
interface mem_arbiter_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_gnt;
  logic        ic_done;
  logic [31:0] ic_data;

  logic        lsb_req;
  logic        lsb_we;
  logic        lsb_sign;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        lsb_gnt;
  logic        lsb_done;
  logic [31:0] lsb_rdata;

  logic        mc_start;
  logic        mc_we;
  logic        mc_sign;
  logic [1:0]  mc_size;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic        mc_done;
  logic [31:0] mc_rdata;

  // arbiter side
  modport slave (
    input  ic_req, ic_addr,
    output ic_gnt, ic_done, ic_data,
    input  lsb_req, lsb_we, lsb_sign, lsb_size, lsb_addr, lsb_wdata,
    output lsb_gnt, lsb_done, lsb_rdata,
    output mc_start, mc_we, mc_sign, mc_size, mc_addr, mc_wdata,
    input  mc_done, mc_rdata
  );

  // requester / engine side
  modport master (
    output ic_req, ic_addr,
    input  ic_gnt, ic_done, ic_data,
    output lsb_req, lsb_we, lsb_sign, lsb_size, lsb_addr, lsb_wdata,
    input  lsb_gnt, lsb_done, lsb_rdata,
    input  mc_start, mc_we, mc_sign, mc_size, mc_addr, mc_wdata,
    output mc_done, mc_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Memory engine arbiter: picks IC or LSB, issues one start pulse to the
// byte-serial engine, and routes the completion back to the winner.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | engine free; winner picked this cycle, granted next cycle
//  BUSY_IC  | instruction fetch outstanding at the engine
//  BUSY_LSB | load/store outstanding at the engine
module mem_arbiter #(
  parameter int         STARVE_LIMIT = 4,
  parameter int         CNT_W        = 3,
  parameter logic [1:0] IO_SEL       = 2'b11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rdy,
  input  logic          clear,
  input  logic          io_buffer_full,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, BUSY_IC, BUSY_LSB} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, state_nx;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nx;
  logic             ic_kill, ic_kill_nx;

  logic        ic_gnt_q, ic_gnt_nx, lsb_gnt_q, lsb_gnt_nx;
  logic        ic_done_q, ic_done_nx, lsb_done_q, lsb_done_nx;
  logic        mc_start_q, mc_start_nx;
  logic        mc_we_q, mc_we_nx, mc_sign_q, mc_sign_nx;
  logic [1:0]  mc_size_q, mc_size_nx;
  logic [31:0] mc_addr_q, mc_addr_nx, mc_wdata_q, mc_wdata_nx;
  logic [31:0] ic_data_q, ic_data_nx, lsb_rdata_q, lsb_rdata_nx;

  logic lsb_ok, ic_ok, win_ic, win_lsb;

  // An IO store waits while the UART buffer is full; a flushed fetch is not eligible.
  assign lsb_ok = bus.lsb_req &&
                  !(bus.lsb_we && bus.lsb_addr[17:16] == IO_SEL && io_buffer_full);
  assign ic_ok  = bus.ic_req && !clear;

  // Next-state, arbitration, starvation counter and registered-output values.
  always_comb begin
    state_nx      = state;
    starve_cnt_nx = starve_cnt;
    ic_kill_nx    = ic_kill;
    win_ic        = 1'b0;
    win_lsb       = 1'b0;
    ic_gnt_nx     = 1'b0;
    lsb_gnt_nx    = 1'b0;
    mc_start_nx   = 1'b0;
    ic_done_nx    = 1'b0;
    lsb_done_nx   = 1'b0;
    mc_we_nx      = mc_we_q;
    mc_sign_nx    = mc_sign_q;
    mc_size_nx    = mc_size_q;
    mc_addr_nx    = mc_addr_q;
    mc_wdata_nx   = mc_wdata_q;
    ic_data_nx    = ic_data_q;
    lsb_rdata_nx  = lsb_rdata_q;

    case (state)
      IDLE: begin
        if (ic_ok && (!lsb_ok || starve_cnt == LIMIT)) begin
          win_ic = 1'b1;
        end else if (lsb_ok) begin
          win_lsb = 1'b1;
        end
        if (win_ic) begin
          state_nx    = BUSY_IC;
          ic_gnt_nx   = 1'b1;
          mc_start_nx = 1'b1;
          mc_we_nx    = 1'b0;
          mc_sign_nx  = 1'b0;
          mc_size_nx  = 2'd3;
          mc_addr_nx  = bus.ic_addr;
          ic_kill_nx  = 1'b0;
        end else if (win_lsb) begin
          state_nx    = BUSY_LSB;
          lsb_gnt_nx  = 1'b1;
          mc_start_nx = 1'b1;
          mc_we_nx    = bus.lsb_we;
          mc_sign_nx  = bus.lsb_sign;
          mc_size_nx  = bus.lsb_size;
          mc_addr_nx  = bus.lsb_addr;
          mc_wdata_nx = bus.lsb_wdata;
        end
      end
      BUSY_IC: begin
        if (clear) begin
          ic_kill_nx = 1'b1;
        end
        if (bus.mc_done) begin
          state_nx   = IDLE;
          ic_kill_nx = 1'b0;
          // a flush in the completion cycle itself also discards the word
          if (!(ic_kill || clear)) begin
            ic_done_nx = 1'b1;
            ic_data_nx = bus.mc_rdata;
          end
        end
      end
      BUSY_LSB: begin
        if (bus.mc_done) begin
          state_nx     = IDLE;
          lsb_done_nx  = 1'b1;
          lsb_rdata_nx = bus.mc_rdata;
        end
      end
      default: state_nx = IDLE;
    endcase

    if (win_ic || !bus.ic_req) begin
      starve_cnt_nx = '0;
    end else if (win_lsb && starve_cnt != LIMIT) begin
      starve_cnt_nx = starve_cnt + 1'b1;
    end
  end

  // State and output registers; rdy low freezes everything and drops pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      ic_kill     <= 1'b0;
      ic_gnt_q    <= 1'b0;
      lsb_gnt_q   <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      mc_start_q  <= 1'b0;
      mc_we_q     <= 1'b0;
      mc_sign_q   <= 1'b0;
      mc_size_q   <= 2'd0;
      mc_addr_q   <= 32'd0;
      mc_wdata_q  <= 32'd0;
      ic_data_q   <= 32'd0;
      lsb_rdata_q <= 32'd0;
    end else if (rdy) begin
      state       <= state_nx;
      starve_cnt  <= starve_cnt_nx;
      ic_kill     <= ic_kill_nx;
      ic_gnt_q    <= ic_gnt_nx;
      lsb_gnt_q   <= lsb_gnt_nx;
      ic_done_q   <= ic_done_nx;
      lsb_done_q  <= lsb_done_nx;
      mc_start_q  <= mc_start_nx;
      mc_we_q     <= mc_we_nx;
      mc_sign_q   <= mc_sign_nx;
      mc_size_q   <= mc_size_nx;
      mc_addr_q   <= mc_addr_nx;
      mc_wdata_q  <= mc_wdata_nx;
      ic_data_q   <= ic_data_nx;
      lsb_rdata_q <= lsb_rdata_nx;
    end else begin
      ic_gnt_q    <= 1'b0;
      lsb_gnt_q   <= 1'b0;
      ic_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      mc_start_q  <= 1'b0;
    end
  end

  assign bus.ic_gnt    = ic_gnt_q;
  assign bus.ic_done   = ic_done_q;
  assign bus.ic_data   = ic_data_q;
  assign bus.lsb_gnt   = lsb_gnt_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;
  assign bus.mc_start  = mc_start_q;
  assign bus.mc_we     = mc_we_q;
  assign bus.mc_sign   = mc_sign_q;
  assign bus.mc_size   = mc_size_q;
  assign bus.mc_addr   = mc_addr_q;
  assign bus.mc_wdata  = mc_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic, with a
// transaction-level arbitration model feeding a scoreboard that a separate
// monitor drains whenever the DUT presents a grant or completion.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic clear = 1'b0;
  logic io_buffer_full = 1'b0;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3), .IO_SEL(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .io_buffer_full(io_buffer_full), .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard state ----------------
  typedef struct {
    bit          is_ic;
    logic        we;
    logic        sign;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } grant_t;

  grant_t      exp_grant[$];
  bit          grant_log[$];   // 1 = IC, 0 = LSB, in grant order
  int          m_out = 0;      // 0 none, 1 IC, 2 LSB outstanding at the engine
  int          m_starve = 0;   // consecutive LSB wins while IC waits
  bit          m_kill = 0;
  bit          m_done_next = 0;
  bit          m_done_ic = 0;
  bit          m_done_killed = 0;
  logic [31:0] m_done_data = '0;
  logic [31:0] m_last_ic = '0;

  // engine controls
  int          eng_min = 1;
  int          eng_max = 3;
  bit          eng_fixed = 0;
  logic [31:0] eng_data = '0;
  bit          stray_req = 0;

  // Monitor: checks grants/completions against the model, then lets the
  // model make this cycle's arbitration decision.
  always @(negedge clk) begin
    grant_t g;
    bit ic_ok, lsb_ok;
    int pick;
    if (!rst) begin
      exp_grant.delete();
      m_out = 0; m_starve = 0; m_kill = 0; m_done_next = 0; m_last_ic = '0;
    end else begin
      if (exp_grant.size() > 0) begin
        g = exp_grant.pop_front();
        check("mc_start", bus.mc_start, 1);
        if (bus.mc_start) begin
          check("winner_gnt", g.is_ic ? bus.ic_gnt : bus.lsb_gnt, 1);
          check("loser_gnt", g.is_ic ? bus.lsb_gnt : bus.ic_gnt, 0);
          check("mc_addr", bus.mc_addr, g.addr);
          check("mc_we", bus.mc_we, g.we);
          check("mc_size", bus.mc_size, g.size);
          if (!g.is_ic) begin
            check("mc_sign", bus.mc_sign, g.sign);
            check("mc_wdata", bus.mc_wdata, g.wdata);
          end
          grant_log.push_back(g.is_ic);
        end
      end else begin
        check("stray_start", {bus.mc_start, bus.ic_gnt, bus.lsb_gnt}, 0);
      end

      if (m_done_next) begin
        m_done_next = 0;
        m_out = 0;
        if (m_done_ic) begin
          check("lsb_done_on_ic", bus.lsb_done, 0);
          if (m_done_killed) begin
            check("ic_done_killed", bus.ic_done, 0);
            check("ic_data_hold", bus.ic_data, m_last_ic);
          end else begin
            check("ic_done", bus.ic_done, 1);
            check("ic_data", bus.ic_data, m_done_data);
            m_last_ic = m_done_data;
          end
        end else begin
          check("ic_done_on_lsb", bus.ic_done, 0);
          check("lsb_done", bus.lsb_done, 1);
          check("lsb_rdata", bus.lsb_rdata, m_done_data);
        end
      end else begin
        check("stray_done", {bus.ic_done, bus.lsb_done}, 0);
      end

      if (rdy) begin
        if (bus.mc_done && m_out != 0) begin
          m_done_next   = 1;
          m_done_ic     = (m_out == 1);
          m_done_killed = (m_out == 1) && (m_kill || clear);
          m_done_data   = bus.mc_rdata;
          m_kill        = 0;
        end else if (m_out == 1 && clear) begin
          m_kill = 1;
        end

        ic_ok  = bus.ic_req && !clear;
        lsb_ok = bus.lsb_req &&
                 !(bus.lsb_we && bus.lsb_addr[17:16] == 2'b11 && io_buffer_full);
        pick = 0;
        if (m_out == 0) begin
          if (ic_ok && (!lsb_ok || m_starve >= 4)) pick = 1;
          else if (lsb_ok) pick = 2;
        end
        if (pick == 1) begin
          g.is_ic = 1; g.we = 0; g.sign = 0; g.size = 2'd3;
          g.addr = bus.ic_addr; g.wdata = '0;
          exp_grant.push_back(g);
          m_out = 1; m_kill = 0;
        end else if (pick == 2) begin
          g.is_ic = 0; g.we = bus.lsb_we; g.sign = bus.lsb_sign; g.size = bus.lsb_size;
          g.addr = bus.lsb_addr; g.wdata = bus.lsb_wdata;
          exp_grant.push_back(g);
          m_out = 2;
        end
        if (pick == 1 || !bus.ic_req) m_starve = 0;
        else if (pick == 2 && m_starve < 4) m_starve++;
      end
    end
  end

  // Engine model: answers each start after a few cycles with one done pulse.
  initial begin
    bus.mc_done  = 1'b0;
    bus.mc_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.mc_start) begin
        repeat ($urandom_range(eng_max, eng_min)) @(posedge clk);
        #1;
        bus.mc_done  = 1'b1;
        bus.mc_rdata = eng_fixed ? eng_data : $urandom;
        @(posedge clk); #1;
        bus.mc_done = 1'b0;
      end else if (stray_req) begin
        bus.mc_done  = 1'b1;
        bus.mc_rdata = $urandom;
        @(posedge clk); #1;
        bus.mc_done = 1'b0;
        stray_req   = 0;
      end
    end
  end

  // ---------------- drivers (called aligned to posedge + #1) ----------------
  task automatic ic_txn(input logic [31:0] addr);
    bit ok = 0;
    bus.ic_req  = 1'b1;
    bus.ic_addr = addr;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.ic_gnt) begin ok = 1; break; end
    end
    bus.ic_req = 1'b0;
    if (!ok) check("ic_gnt_timeout", ok, 1);
  endtask

  task automatic lsb_txn(input logic we, input logic sign, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
    bit ok = 0;
    bus.lsb_req   = 1'b1;
    bus.lsb_we    = we;
    bus.lsb_sign  = sign;
    bus.lsb_size  = size;
    bus.lsb_addr  = addr;
    bus.lsb_wdata = wdata;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (bus.lsb_gnt) begin ok = 1; break; end
    end
    if (!keep) bus.lsb_req = 1'b0;
    if (!ok) check("lsb_gnt_timeout", ok, 1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (m_out == 0 && !m_done_next && exp_grant.size() == 0 &&
          !bus.ic_req && !bus.lsb_req) begin ok = 1; break; end
    end
    if (!ok) check("idle_timeout", ok, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, {bus.ic_gnt, bus.lsb_gnt, bus.ic_done, bus.lsb_done,
                             bus.mc_start, bus.mc_we, bus.mc_sign, bus.mc_size}, 0);
    check({tag, "_mc_addr"}, bus.mc_addr, 0);
    check({tag, "_mc_wdata"}, bus.mc_wdata, 0);
    check({tag, "_ic_data"}, bus.ic_data, 0);
    check({tag, "_lsb_rdata"}, bus.lsb_rdata, 0);
  endtask

  task automatic check_log(input string name, input bit pat[$]);
    check({name, "_count"}, grant_log.size(), pat.size());
    for (int i = 0; i < pat.size() && i < grant_log.size(); i++)
      check($sformatf("%s_%0d", name, i), grant_log[i], pat[i]);
  endtask

  task automatic ic_loop(input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      ic_txn($urandom & 32'hFFFF_FFFC);
    end
  endtask

  task automatic lsb_loop(input int n);
    logic [1:0] sz;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      case ($urandom_range(0, 2))
        0: sz = 2'd0;
        1: sz = 2'd1;
        default: sz = 2'd3;
      endcase
      lsb_txn($urandom_range(0, 1), $urandom_range(0, 1), sz, $urandom, $urandom, 0);
    end
  endtask

  // Global time limit.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit pat[$];
    bit rand_run;
    int fall_cyc;
    int gnt_cyc;
    bus.ic_req = 0; bus.ic_addr = '0;
    bus.lsb_req = 0; bus.lsb_we = 0; bus.lsb_sign = 0; bus.lsb_size = '0;
    bus.lsb_addr = '0; bus.lsb_wdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // IC only, fixed engine data
    eng_fixed = 1; eng_data = 32'hDEAD_BEEF; eng_min = 2; eng_max = 2;
    grant_log.delete();
    ic_txn(32'h0000_1000);
    check("ic_only_start", bus.mc_start, 1);
    check("ic_only_addr", bus.mc_addr, 32'h0000_1000);
    check("ic_only_size", bus.mc_size, 2'd3);
    wait_idle();
    check("ic_only_data", bus.ic_data, 32'hDEAD_BEEF);
    eng_fixed = 0;

    // clear during BUSY_IC: completion is swallowed, old word stays
    eng_min = 3; eng_max = 3;
    ic_txn(32'h0000_5000);
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_idle();
    check("kill_data_kept", bus.ic_data, 32'hDEAD_BEEF);
    ic_txn(32'h0000_5004);
    wait_idle();
    pat = '{1, 1, 1};
    check_log("ic_log", pat);
    eng_min = 1; eng_max = 3;

    // simultaneous requests with no starvation history: LSB first
    grant_log.delete();
    fork
      ic_txn(32'h0000_1004);
      lsb_txn(0, 0, 2'd3, 32'h0000_2000, 32'h0, 0);
    join
    wait_idle();
    pat = '{0, 1};
    check_log("simul", pat);

    // starvation: six back-to-back loads against a waiting fetch
    grant_log.delete();
    fork
      ic_txn(32'h0000_4000);
      for (int i = 0; i < 6; i++) lsb_txn(0, 1, 2'd1, 32'h0000_8000 + 4 * i, 32'h0, i < 5);
    join
    wait_idle();
    pat = '{0, 0, 0, 0, 1, 0, 0};
    check_log("starve", pat);

    // IO store held off by a full UART buffer
    grant_log.delete();
    io_buffer_full = 1'b1;
    fall_cyc = 0;
    fork
      begin
        lsb_txn(1, 0, 2'd0, 32'h0003_0000, 32'h0000_0041, 0);
        gnt_cyc = cyc;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        io_buffer_full = 1'b0;
        fall_cyc = cyc;
      end
    join
    check("io_grant_latency", gnt_cyc - fall_cyc, 1);
    wait_idle();

    // engine done while idle is ignored
    stray_req = 1;
    repeat (5) @(posedge clk);
    #1;

    // rdy low freezes arbitration
    rdy = 1'b0;
    bus.ic_req = 1'b1;
    bus.ic_addr = 32'h0000_6000;
    repeat (3) begin
      @(posedge clk); #1;
      check("frozen_no_gnt", {bus.ic_gnt, bus.mc_start}, 0);
    end
    rdy = 1'b1;
    ic_txn(32'h0000_6000);
    wait_idle();

    // randomized mixed traffic with clear and io_buffer_full noise
    rand_run = 1;
    fork
      begin
        while (rand_run) begin
          @(posedge clk); #1;
          io_buffer_full = ($urandom_range(0, 3) == 0);
          clear = ($urandom_range(0, 9) == 0);
        end
      end
      begin
        fork
          ic_loop(25);
          lsb_loop(25);
        join
        rand_run = 0;
      end
    join
    io_buffer_full = 1'b0;
    clear = 1'b0;
    wait_idle();

    // reset while an LSB access is outstanding
    eng_min = 4; eng_max = 4;
    lsb_txn(0, 0, 2'd3, 32'h0000_7000, 32'h0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    eng_min = 1; eng_max = 3;
    grant_log.delete();
    lsb_txn(0, 0, 2'd3, 32'h0000_7004, 32'h0, 0);
    wait_idle();
    pat = '{0};
    check_log("after_rst", pat);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
